scoreboard: RTL and testbench

- Consumer end of the decode/issue interface built on the scoreboard_entry type.
- Accepts decoded scoreboard_entry records from issue and assigns each a trans_id.
- Collects out-of-order writebacks from NR_WB_PORTS functional units, addressed by trans_id.
- Presents the oldest entry to commit, in program order, once its result is valid.

---
 rtl/scoreboard.sv | 165 ++++++++++++++++
 tb/tb_scoreboard.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard.sv
// Scoreboard: in-order tracking of issued instructions with out-of-order
// writeback collection and in-order commit of the oldest completed entry.

package scoreboard_pkg;

    // Default depth of the scoreboard and the matching trans_id width
    localparam int NR_SB_ENTRIES    = 4;
    localparam int SB_TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    // Exception record carried with every instruction
    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    // Decoded instruction as handed over by issue and presented to commit
    typedef struct packed {
        logic [63:0]                 pc;
        logic [SB_TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]                  fu;
        logic [7:0]                  op;
        logic [4:0]                  rs1;
        logic [4:0]                  rs2;
        logic [4:0]                  rd;
        logic [63:0]                 result;
        logic                        valid;
        exception_t                  ex;
    } scoreboard_entry_t;

endpackage

module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int NR_ENTRIES    = NR_SB_ENTRIES,
    parameter int NR_WB_PORTS   = 3,
    parameter int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,

    input  scoreboard_entry_t                         decoded_instr_i,
    input  logic                                      decoded_instr_valid_i,
    output logic                                      decoded_instr_ack_o,
    output logic [TRANS_ID_BITS-1:0]                  issue_trans_id_o,
    output logic                                      full_o,

    output scoreboard_entry_t                         commit_instr_o,
    output logic                                      commit_valid_o,
    input  logic                                      commit_ack_i,

    input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]              wb_data_i,
    input  exception_t [NR_WB_PORTS-1:0]              wb_ex_i
);

    localparam int CNT_BITS = TRANS_ID_BITS + 1;

    localparam logic [TRANS_ID_BITS-1:0] PTR_ONE  = TRANS_ID_BITS'(1);
    localparam logic [CNT_BITS-1:0]      CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]      CNT_FULL = CNT_BITS'(NR_ENTRIES);

    // Circular buffer of entries plus per-slot occupancy
    scoreboard_entry_t mem_q [NR_ENTRIES];
    scoreboard_entry_t mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] busy_q;
    logic [NR_ENTRIES-1:0] busy_d;

    // Pointers and occupancy count
    logic [TRANS_ID_BITS-1:0] head_q;
    logic [TRANS_ID_BITS-1:0] head_d;
    logic [TRANS_ID_BITS-1:0] tail_q;
    logic [TRANS_ID_BITS-1:0] tail_d;
    logic [CNT_BITS-1:0]      count_q;
    logic [CNT_BITS-1:0]      count_d;

    // Handshake qualifiers for this cycle
    logic issue_fire;
    logic commit_fire;

    // Outputs derived purely from registered state, except the issue ack
    always_comb begin
        full_o              = (count_q == CNT_FULL);
        issue_trans_id_o    = tail_q;
        decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
        commit_instr_o      = mem_q[head_q];
        commit_valid_o      = (count_q != '0) & mem_q[head_q].valid & busy_q[head_q];
        issue_fire          = decoded_instr_ack_o;
        commit_fire         = commit_ack_i & commit_valid_o;
    end

    // Next-state: writeback, then commit, then issue, with flush overriding all
    always_comb begin
        mem_d   = mem_q;
        busy_d  = busy_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // Writebacks only land on slots occupied at the start of the cycle;
        // ascending port order lets the highest port index win on collisions.
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p] && busy_q[wb_trans_id_i[p]]) begin
                mem_d[wb_trans_id_i[p]].result = wb_data_i[p];
                mem_d[wb_trans_id_i[p]].valid  = 1'b1;
                if (wb_ex_i[p].valid) begin
                    mem_d[wb_trans_id_i[p]].ex = wb_ex_i[p];
                end
            end
        end

        // Retiring the head frees its slot; any writeback into it is moot
        if (commit_fire) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + PTR_ONE;
        end

        // A new entry overwrites whatever a writeback did to the (free) tail slot;
        // a decode-time exception makes the entry committable immediately.
        if (issue_fire) begin
            mem_d[tail_q]          = decoded_instr_i;
            mem_d[tail_q].trans_id = SB_TRANS_ID_BITS'(tail_q);
            mem_d[tail_q].valid    = decoded_instr_i.ex.valid;
            busy_d[tail_q]         = 1'b1;
            tail_d                 = tail_q + PTR_ONE;
        end

        case ({issue_fire, commit_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (flush_i) begin
            busy_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never reset; busy gates every use of it
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: directed scenarios followed by random
// traffic, all compared against a program-order queue model.

module tb_scoreboard;
   import scoreboard_pkg::*;

   localparam int NE = 4;
   localparam int NP = 3;
   localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

   logic clk = 1'b0;
   logic rst_ni;
   logic flush_i;
   scoreboard_entry_t decoded_instr_i;
   logic decoded_instr_valid_i;
   logic decoded_instr_ack_o;
   logic [1:0] issue_trans_id_o;
   logic full_o;
   scoreboard_entry_t commit_instr_o;
   logic commit_valid_o;
   logic commit_ack_i;
   logic [NP-1:0] wb_valid_i;
   logic [NP-1:0][1:0] wb_trans_id_i;
   logic [NP-1:0][63:0] wb_data_i;
   exception_t [NP-1:0] wb_ex_i;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   // Reference model: in-flight instructions in program order
   scoreboard_entry_t modelQ[$];
   int modelIssued = 0;

   scoreboard #(.NR_ENTRIES(NE), .NR_WB_PORTS(NP)) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_ni),
      .flush_i               (flush_i),
      .decoded_instr_i       (decoded_instr_i),
      .decoded_instr_valid_i (decoded_instr_valid_i),
      .decoded_instr_ack_o   (decoded_instr_ack_o),
      .issue_trans_id_o      (issue_trans_id_o),
      .full_o                (full_o),
      .commit_instr_o        (commit_instr_o),
      .commit_valid_o        (commit_valid_o),
      .commit_ack_i          (commit_ack_i),
      .wb_valid_i            (wb_valid_i),
      .wb_trans_id_i         (wb_trans_id_i),
      .wb_data_i             (wb_data_i),
      .wb_ex_i               (wb_ex_i)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic idleInputs();
      rst_ni = 1'b1;
      flush_i = 1'b0;
      decoded_instr_valid_i = 1'b0;
      decoded_instr_i = '0;
      commit_ack_i = 1'b0;
      wb_valid_i = '0;
      wb_trans_id_i = '0;
      wb_data_i = '0;
      wb_ex_i = '0;
   endtask

   task automatic setIssue(input logic [63:0] pc);
      decoded_instr_valid_i = 1'b1;
      decoded_instr_i = '0;
      decoded_instr_i.pc = pc;
      decoded_instr_i.rd = pc[6:2];
   endtask

   task automatic setWb(input int p, input logic [1:0] id, input logic [63:0] data);
      wb_valid_i[p] = 1'b1;
      wb_trans_id_i[p] = id;
      wb_data_i[p] = data;
      wb_ex_i[p] = '0;
   endtask

   // One clock cycle: compare outputs at the falling edge, advance the model, cross the rising edge
   task automatic applyStimulus();
      bit mFull, mValid, mAck;
      scoreboard_entry_t e;
      @(negedge clk);
      mFull = (modelQ.size() == NE);
      mValid = (modelQ.size() != 0) && modelQ[0].valid;
      mAck = decoded_instr_valid_i && !mFull && !flush_i;
      if (checking) begin
         checkOutput("ack", 64'(decoded_instr_ack_o), 64'(mAck));
         checkOutput("issue_id", 64'(issue_trans_id_o), 64'(modelIssued % NE));
         checkOutput("full", 64'(full_o), 64'(mFull));
         checkOutput("commit_valid", 64'(commit_valid_o), 64'(mValid));
         if (mValid) begin
            checkOutput("commit_pc", commit_instr_o.pc, modelQ[0].pc);
            checkOutput("commit_result", commit_instr_o.result, modelQ[0].result);
            checkOutput("commit_trans_id", 64'(commit_instr_o.trans_id), 64'(modelQ[0].trans_id));
            checkOutput("commit_ex_valid", 64'(commit_instr_o.ex.valid), 64'(modelQ[0].ex.valid));
            checkOutput("commit_ex_cause", commit_instr_o.ex.cause, modelQ[0].ex.cause);
         end
      end
      if (!rst_ni || flush_i) begin
         modelQ.delete();
         modelIssued = 0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            if (wb_valid_i[p]) begin
               foreach (modelQ[i]) begin
                  if (modelQ[i].trans_id == wb_trans_id_i[p]) begin
                     modelQ[i].result = wb_data_i[p];
                     modelQ[i].valid = 1'b1;
                     if (wb_ex_i[p].valid) modelQ[i].ex = wb_ex_i[p];
                  end
               end
            end
         end
         if (commit_ack_i && mValid) void'(modelQ.pop_front());
         if (mAck) begin
            e = decoded_instr_i;
            e.trans_id = 2'(modelIssued % NE);
            e.valid = e.ex.valid;
            modelQ.push_back(e);
            modelIssued++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] freedId;
      idleInputs();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checking = 1'b1;
      applyStimulus();
      idleInputs();

      $display("[TB] reset state");
      checkOutput("rst_full", 64'(full_o), 64'd0);
      checkOutput("rst_commit_valid", 64'(commit_valid_o), 64'd0);
      checkOutput("rst_issue_id", 64'(issue_trans_id_o), 64'd0);

      $display("[TB] fill four entries");
      for (int k = 0; k < 4; k++) begin
         idleInputs();
         setIssue(64'h80 + 64'(4 * k));
         checkOutput("t1_id", 64'(issue_trans_id_o), 64'(k));
         applyStimulus();
      end
      checkOutput("t1_full", 64'(full_o), 64'd1);
      setIssue(64'h90);
      applyStimulus();

      $display("[TB] out-of-order writeback");
      idleInputs();
      setWb(1, 2'd2, 64'hBEEF);
      applyStimulus();
      checkOutput("t2_valid_after_id2", 64'(commit_valid_o), 64'd0);
      idleInputs();
      setWb(0, 2'd0, 64'h1234);
      applyStimulus();
      checkOutput("t2_valid_after_id0", 64'(commit_valid_o), 64'd1);
      checkOutput("t2_pc", commit_instr_o.pc, 64'h80);
      checkOutput("t2_result", commit_instr_o.result, 64'h1234);
      idleInputs();
      commit_ack_i = 1'b1;
      applyStimulus();
      checkOutput("t2_stall_id1", 64'(commit_valid_o), 64'd0);
      applyStimulus();

      $display("[TB] same-id writeback collision");
      idleInputs();
      setWb(0, 2'd1, 64'hAA);
      setWb(2, 2'd1, 64'hCC);
      applyStimulus();
      checkOutput("t3_result", commit_instr_o.result, 64'hCC);
      checkOutput("t3_pc", commit_instr_o.pc, 64'h84);
      idleInputs();
      commit_ack_i = 1'b1;
      applyStimulus();
      applyStimulus();
      idleInputs();
      setWb(0, 2'd3, 64'h3333);
      applyStimulus();
      idleInputs();
      commit_ack_i = 1'b1;
      applyStimulus();
      idleInputs();
      checkOutput("t3_empty_valid", 64'(commit_valid_o), 64'd0);

      $display("[TB] serial issue/writeback/commit with wrap");
      for (int k = 0; k < 6; k++) begin
         idleInputs();
         setIssue(64'h1000 + 64'(4 * k));
         checkOutput("t4_id", 64'(issue_trans_id_o), 64'(k % 4));
         applyStimulus();
         idleInputs();
         setWb($urandom_range(0, NP - 1), 2'(k % 4), 64'(k) + 64'h500);
         applyStimulus();
         idleInputs();
         commit_ack_i = 1'b1;
         applyStimulus();
      end

      $display("[TB] commit while full");
      for (int k = 0; k < 4; k++) begin
         idleInputs();
         setIssue(64'h2000 + 64'(4 * k));
         applyStimulus();
      end
      idleInputs();
      setWb(1, modelQ[0].trans_id, 64'h77);
      applyStimulus();
      freedId = modelQ[0].trans_id;
      idleInputs();
      commit_ack_i = 1'b1;
      setIssue(64'h2100);
      applyStimulus();
      idleInputs();
      setIssue(64'h2100);
      checkOutput("t5_freed_id", 64'(issue_trans_id_o), 64'(freedId));
      applyStimulus();

      $display("[TB] flush and reset with pending entries");
      for (int r = 0; r < 2; r++) begin
         idleInputs();
         flush_i = 1'b1;
         applyStimulus();
         for (int k = 0; k < 3; k++) begin
            idleInputs();
            setIssue(64'h3000 + 64'(4 * k));
            applyStimulus();
         end
         idleInputs();
         if (r == 0) flush_i = 1'b1;
         else rst_ni = 1'b0;
         setWb(0, 2'd0, 64'h9999);
         setIssue(64'h3100);
         applyStimulus();
         idleInputs();
         checkOutput("t6_valid", 64'(commit_valid_o), 64'd0);
         checkOutput("t6_full", 64'(full_o), 64'd0);
         checkOutput("t6_issue_id", 64'(issue_trans_id_o), 64'd0);
      end

      $display("[TB] decode-time exception");
      idleInputs();
      setIssue(64'h4000);
      decoded_instr_i.ex.valid = 1'b1;
      decoded_instr_i.ex.cause = ILLEGAL_INSTR;
      applyStimulus();
      idleInputs();
      checkOutput("t7_valid", 64'(commit_valid_o), 64'd1);
      checkOutput("t7_cause", commit_instr_o.ex.cause, ILLEGAL_INSTR);
      commit_ack_i = 1'b1;
      applyStimulus();

      $display("[TB] random traffic");
      for (int c = 0; c < 800; c++) begin
         idleInputs();
         rst_ni = ($urandom_range(0, 149) != 0);
         flush_i = ($urandom_range(0, 49) == 0);
         decoded_instr_valid_i = ($urandom_range(0, 2) != 0);
         decoded_instr_i.pc = {32'($urandom), 32'($urandom)};
         decoded_instr_i.op = 8'($urandom);
         decoded_instr_i.rd = 5'($urandom);
         decoded_instr_i.result = {32'($urandom), 32'($urandom)};
         decoded_instr_i.ex.valid = ($urandom_range(0, 9) == 0);
         decoded_instr_i.ex.cause = 64'($urandom_range(0, 15));
         commit_ack_i = ($urandom_range(0, 2) != 0);
         for (int p = 0; p < NP; p++) begin
            wb_valid_i[p] = ($urandom_range(0, 2) == 0);
            wb_trans_id_i[p] = 2'($urandom);
            wb_data_i[p] = {32'($urandom), 32'($urandom)};
            wb_ex_i[p].valid = ($urandom_range(0, 7) == 0);
            wb_ex_i[p].cause = 64'($urandom_range(0, 15));
            wb_ex_i[p].tval = 64'($urandom);
         end
         applyStimulus();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
